// File: rtl/rf_text_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rf_text_pkg
// Description : Shared definitions for the text-mode pixel path. Holds the
//               character attribute bit positions, the attribute type and the
//               default colour width.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_text_pkg;

    // Attribute nibble layout: {cursor, blink, underline, reverse}
    localparam int ATTR_REVERSE = 0;
    localparam int ATTR_UL      = 1;
    localparam int ATTR_BLINK   = 2;
    localparam int ATTR_CURSOR  = 3;

    typedef logic [3:0] attr_t;

    localparam int COLOR_BITS_DEFAULT = 24;

endpackage : rf_text_pkg
`default_nettype wire

// File: rtl/rf_text_pixel_shifter_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_det
// Description : Rising-edge detector. Registers the input once and flags the
//               clock in which it goes from 0 to 1, so a level held for many
//               clocks produces a single one-clock pulse.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               d     - level input (already in the clk domain)
//               rise  - one-clock pulse on a 0->1 transition of d
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule : edge_det
`default_nettype wire

// File: rtl/rf_text_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : rf_text_pixel_shifter
// Description : Serialises one glyph row per character cell into one colour
//               value per dot clock, applying fg/bg colour, reverse video,
//               underline, blink and cursor overlay.
// Ports       : dot_clk_i      - dot clock
//               rst_ni         - asynchronous active-low reset
//               ce_i           - character-cell strobe (RAM read request)
//               bmp_i          - glyph row, bit 0 leftmost (valid ce_i + 1)
//               fg_i, bg_i     - cell colours (valid with bmp_i)
//               attr_i         - {cursor, blink, underline, reverse}
//               maxScanpix_i   - last pixel index in a cell
//               scanline_i     - scanline within the cell (valid with bmp_i)
//               ulRow_i        - underline scanline
//               curStart_i/curEnd_i - inclusive cursor scanline range
//               hscale_i       - each pixel held hscale_i+1 clocks
//               vsync_i        - frame pulse, edge detected
//               blank_i        - forces output to zero (1-clock latency)
//               rgb_o          - registered pixel colour
//               blinkPhase_o   - current blink phase
// Revision    : 1.0 - initial release
// ============================================================================
module rf_text_pixel_shifter
    import rf_text_pkg::*;
#(
    parameter int pColorBits  = COLOR_BITS_DEFAULT,
    parameter int pBlinkShift = 4
) (
    input  logic                  dot_clk_i,
    input  logic                  rst_ni,
    input  logic                  ce_i,
    input  logic [63:0]           bmp_i,
    input  logic [pColorBits-1:0] fg_i,
    input  logic [pColorBits-1:0] bg_i,
    input  logic [3:0]            attr_i,
    input  logic [5:0]            maxScanpix_i,
    input  logic [5:0]            scanline_i,
    input  logic [5:0]            ulRow_i,
    input  logic [5:0]            curStart_i,
    input  logic [5:0]            curEnd_i,
    input  logic [1:0]            hscale_i,
    input  logic                  vsync_i,
    input  logic                  blank_i,
    output logic [pColorBits-1:0] rgb_o,
    output logic                  blinkPhase_o
);

    // ------------------------------------------------------------------
    // Cell state
    // ------------------------------------------------------------------
    logic                  ld;
    logic [63:0]           shreg;
    logic [5:0]            pix;
    logic [1:0]            rep;
    logic [pColorBits-1:0] fg_q;
    logic [pColorBits-1:0] bg_q;
    attr_t                 attr_q;
    logic                  ul_q;
    logic                  cur_q;

    // Blink state
    logic [pBlinkShift:0]  frame_cnt;
    logic                  vsync_rise;
    logic                  blink_phase;

    logic                  dot;

    // ------------------------------------------------------------------
    // Frame counter for blink; MSB is the blink phase
    // ------------------------------------------------------------------
    edge_det u_vsync_edge (
        .clk   (dot_clk_i),
        .rst_n (rst_ni),
        .d     (vsync_i),
        .rise  (vsync_rise)
    );

    always_ff @(posedge dot_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt <= '0;
        end else if (vsync_rise) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink_phase  = frame_cnt[pBlinkShift];
    assign blinkPhase_o = blink_phase;

    // ------------------------------------------------------------------
    // Load / shift. ld is the RAM read strobe delayed to line up with the
    // RAM data; a new load always wins over any remainder of the old cell.
    // ------------------------------------------------------------------
    always_ff @(posedge dot_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld     <= 1'b0;
            shreg  <= '0;
            pix    <= '0;
            rep    <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
            attr_q <= '0;
            ul_q   <= 1'b0;
            cur_q  <= 1'b0;
        end else begin
            ld <= ce_i;
            if (ld) begin
                shreg  <= bmp_i;
                fg_q   <= fg_i;
                bg_q   <= bg_i;
                attr_q <= attr_i;
                ul_q   <= (scanline_i == ulRow_i);
                cur_q  <= (scanline_i >= curStart_i) && (scanline_i <= curEnd_i);
                pix    <= '0;
                rep    <= '0;
            end else if (rep == hscale_i) begin
                rep   <= '0;
                shreg <= shreg >> 1;
                // Saturating so the gap test below stays true for long lines
                if (pix != 6'd63) begin
                    pix <= pix + 6'd1;
                end
            end else begin
                rep <= rep + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overlay chain: gap -> underline -> blink -> reverse -> cursor.
    // Underline is applied before reverse so it inverts along with the glyph.
    // ------------------------------------------------------------------
    always_comb begin
        dot = (pix <= maxScanpix_i) ? shreg[0] : 1'b0;
        dot = dot | (ul_q & attr_q[ATTR_UL]);
        if (attr_q[ATTR_BLINK] & blink_phase) begin
            dot = 1'b0;
        end
        dot = dot ^ attr_q[ATTR_REVERSE];
        if (attr_q[ATTR_CURSOR] & cur_q & blink_phase) begin
            dot = ~dot;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge dot_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o <= '0;
        end else if (blank_i) begin
            rgb_o <= '0;
        end else begin
            rgb_o <= dot ? fg_q : bg_q;
        end
    end

endmodule : rf_text_pixel_shifter
`default_nettype wire
